maze_ctrl: RTL and testbench

- Sequencing controller for the maze solver: runs a depth-first search over an external 1-bit-per-cell maze memory, then replays the found path as a Move stream.
- The search starts from the top-left corner and ends at the bottom-right corner.
- Owns the path stack, the position registers and the search/replay FSM. The maze RAM is external.
- Start launches the search. Run launches the replay. Fail and Done report the search result.

---
 rtl/maze_pkg.sv | 47 ++++
 rtl/maze_path_stack.sv | 47 ++++
 rtl/maze_ctrl.sv | 164 ++++++++++++++++
 tb/tb_maze_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared types and position helpers for the maze search controller.
// Positions are carried at POS_W bits so a step can run past the edge and be caught as out of bounds.
package maze_pkg;

    localparam int POS_W = 8;  // holds ROW_W/COL_W up to 7 plus one overflow bit

    typedef enum logic [1:0] {
        RIGHT = 2'b00,
        DOWN  = 2'b01,
        LEFT  = 2'b10,
        UP    = 2'b11
    } dir_t;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        INIT_CHK,
        CHECK,
        EVAL,
        BACK,
        SOLVED,
        FAILED,
        REPLAY
    } state_t;

    typedef struct packed {
        logic [POS_W-1:0] row;
        logic [POS_W-1:0] col;
    } pos_t;

    function automatic dir_t opposite(dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

    // Stepping off row/col 0 wraps to all-ones, which the caller sees as out of bounds.
    function automatic pos_t step(pos_t p, dir_t d);
        pos_t s = p;
        case (d)
            RIGHT:   s.col = p.col + POS_W'(1);
            DOWN:    s.row = p.row + POS_W'(1);
            LEFT:    s.col = p.col - POS_W'(1);
            default: s.row = p.row - POS_W'(1);
        endcase
        return s;
    endfunction

endpackage

// File: rtl/maze_path_stack.sv
// Path stack of 2-bit moves: push/pop at the top plus an indexed read port used for replay.
module maze_path_stack #(
    parameter int STACK_DEPTH = 256,
    parameter int IDX_W       = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1,
    parameter int CNT_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [1:0]       push_data,
    output logic [1:0]       top_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [1:0]       rd_data,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    logic [1:0]       mem [STACK_DEPTH];
    logic [CNT_W-1:0] cnt;

    assign empty    = (cnt == '0);
    assign full     = (cnt == CNT_W'(STACK_DEPTH));
    assign count    = cnt;
    assign top_data = mem[IDX_W'(cnt - CNT_W'(1))];
    assign rd_data  = mem[rd_idx];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (push && !full) begin
            cnt <= cnt + CNT_W'(1);
        end else if (pop && !empty) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Entries are left in place on pop and clear; only the count decides what is live.
    always_ff @(posedge clk) begin
        if (!rst && !clr && push && !full) begin
            mem[IDX_W'(cnt)] <= push_data;
        end
    end

endmodule

// File: rtl/maze_ctrl.sv
// Depth-first maze search over an external 1-bit cell RAM, then replay of the found path as moves.
// Define MAZE_CTRL_STATS_EN to add the backtrack_cnt output.
module maze_ctrl
    import maze_pkg::*;
#(
    parameter int ROW_W       = 4,
    parameter int COL_W       = 4,
    parameter int STACK_DEPTH = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   Start,
    input  logic                   Run,
    output logic [ROW_W+COL_W-1:0] mem_addr,
    output logic                   mem_rd,
    input  logic                   mem_rdata,
    output logic                   mem_we,
    output logic                   Fail,
    output logic                   Done,
    output logic [1:0]             Move,
`ifdef MAZE_CTRL_STATS_EN
    output logic [15:0]            backtrack_cnt,
`endif
    output logic                   Move_valid
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int CNT_W = $clog2(STACK_DEPTH + 1);
    localparam logic [POS_W-1:0] ROW_MAX = POS_W'((1 << ROW_W) - 1);
    localparam logic [POS_W-1:0] COL_MAX = POS_W'((1 << COL_W) - 1);

    state_t           state, state_n;
    pos_t             pos, nbr, bpos, addr_pos;
    logic [2:0]       dir_cnt;  // bit 2 set means all four directions tried
    dir_t             dir;
    logic [IDX_W-1:0] ridx;
    logic             at_goal, exhausted, oob, start_ok, last;
    logic             push, pop, empty, full;
    logic [1:0]       top_data, rd_data;
    logic [CNT_W-1:0] depth;

    assign dir       = dir_t'(dir_cnt[1:0]);
    assign nbr       = step(pos, dir);
    assign bpos      = step(pos, opposite(dir_t'(top_data)));
    assign at_goal   = (pos.row == ROW_MAX) && (pos.col == COL_MAX);
    assign exhausted = dir_cnt[2];
    assign oob       = (|nbr.row[POS_W-1:ROW_W]) || (|nbr.col[POS_W-1:COL_W]);
    assign start_ok  = Start && (state inside {IDLE, SOLVED, FAILED});
    assign last      = (CNT_W'(ridx) == depth - CNT_W'(1));
    assign addr_pos  = (state == CHECK || state == EVAL) ? nbr : pos;
    assign mem_addr  = {addr_pos.row[ROW_W-1:0], addr_pos.col[COL_W-1:0]};

    maze_path_stack #(.STACK_DEPTH(STACK_DEPTH)) u_stack (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_ok),
        .push      (push),
        .pop       (pop),
        .push_data (dir),
        .top_data  (top_data),
        .rd_idx    (ridx),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (depth)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, FAILED: if (start_ok) state_n = INIT;
            SOLVED: begin
                if (start_ok)          state_n = INIT;
                else if (Run && !empty) state_n = REPLAY;
            end
            INIT:     state_n = INIT_CHK;
            INIT_CHK: state_n = mem_rdata ? FAILED : CHECK;
            CHECK: begin
                if (at_goal)        state_n = SOLVED;
                else if (exhausted) state_n = BACK;
                else if (!oob)      state_n = EVAL;
            end
            EVAL:   state_n = (!mem_rdata && full) ? FAILED : CHECK;
            BACK:   state_n = empty ? FAILED : CHECK;
            REPLAY: if (last) state_n = SOLVED;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        mem_rd     = 1'b0;
        mem_we     = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        Fail       = 1'b0;
        Done       = 1'b0;
        Move       = 2'b00;
        Move_valid = 1'b0;
        case (state)
            INIT:     mem_rd = 1'b1;
            INIT_CHK: mem_we = !mem_rdata;
            CHECK:    mem_rd = !at_goal && !exhausted && !oob;
            EVAL: begin
                push   = !mem_rdata && !full;
                mem_we = !mem_rdata && !full;
            end
            BACK:   pop  = !empty;
            SOLVED: Done = 1'b1;
            FAILED: Fail = 1'b1;
            REPLAY: begin
                Move_valid = 1'b1;
                Move       = rd_data;
            end
            default: ;
        endcase
    end

    // Upper position bits stay zero: only in-bounds neighbours and back-steps are ever loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos     <= '0;
            dir_cnt <= '0;
            ridx    <= '0;
        end else begin
            case (state)
                IDLE, SOLVED, FAILED: begin
                    ridx <= '0;
                    if (start_ok) pos <= '0;
                end
                INIT_CHK: dir_cnt <= '0;
                CHECK: if (!at_goal && !exhausted && oob) dir_cnt <= dir_cnt + 3'd1;
                EVAL: begin
                    if (mem_rdata) begin
                        dir_cnt <= dir_cnt + 3'd1;
                    end else if (!full) begin
                        pos     <= nbr;
                        dir_cnt <= '0;
                    end
                end
                BACK: begin
                    if (!empty) begin
                        pos     <= bpos;
                        dir_cnt <= {1'b0, top_data} + 3'd1;
                    end
                end
                REPLAY: ridx <= ridx + IDX_W'(1);
                default: ;
            endcase
        end
    end

`ifdef MAZE_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst || start_ok)                     backtrack_cnt <= '0;
        else if (pop && backtrack_cnt != 16'hFFFF) backtrack_cnt <= backtrack_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_maze_ctrl.sv
// Directed bench for maze_ctrl on 4x4 maps: DUT a with a deep stack, DUT b with a 4-entry stack.
module tb_maze_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, run, ld;
    logic [15:0] ld_map, map_a, map_b;
    logic [3:0]  addr_a, addr_b;
    logic        rd_a, rd_b, we_a, we_b, rdata_a, rdata_b;
    logic        fail_a, fail_b, done_a, done_b, mv_a, mv_b;
    logic [1:0]  move_a, move_b;
    int          wr_a [16];
    int          wr_b [16];
    int          nvec = 0;
    int          nerr = 0;
    logic        excl_bad = 1'b0;
`ifdef MAZE_CTRL_STATS_EN
    logic [15:0] bt_a, bt_b;
`endif

    maze_ctrl #(.ROW_W(2), .COL_W(2), .STACK_DEPTH(256)) u_dut_a (
        .clk(clk), .rst(rst), .Start(start), .Run(run),
        .mem_addr(addr_a), .mem_rd(rd_a), .mem_rdata(rdata_a), .mem_we(we_a),
        .Fail(fail_a), .Done(done_a), .Move(move_a),
`ifdef MAZE_CTRL_STATS_EN
        .backtrack_cnt(bt_a),
`endif
        .Move_valid(mv_a)
    );

    maze_ctrl #(.ROW_W(2), .COL_W(2), .STACK_DEPTH(4)) u_dut_b (
        .clk(clk), .rst(rst), .Start(start), .Run(run),
        .mem_addr(addr_b), .mem_rd(rd_b), .mem_rdata(rdata_b), .mem_we(we_b),
        .Fail(fail_b), .Done(done_b), .Move(move_b),
`ifdef MAZE_CTRL_STATS_EN
        .backtrack_cnt(bt_b),
`endif
        .Move_valid(mv_b)
    );

    // Maze RAMs with one-cycle read latency and per-cell write counters.
    always @(posedge clk) begin
        if (ld) begin
            map_a <= ld_map;
            map_b <= ld_map;
            for (int i = 0; i < 16; i++) begin
                wr_a[i] <= 0;
                wr_b[i] <= 0;
            end
        end else begin
            if (rd_a) rdata_a <= map_a[addr_a];
            if (rd_b) rdata_b <= map_b[addr_b];
            if (we_a) begin
                map_a[addr_a] <= 1'b1;
                wr_a[addr_a]  <= wr_a[addr_a] + 1;
            end
            if (we_b) begin
                map_b[addr_b] <= 1'b1;
                wr_b[addr_b]  <= wr_b[addr_b] + 1;
            end
        end
        if ((rd_a && we_a) || (rd_b && we_b) || (done_a && fail_a) || (done_b && fail_b))
            excl_bad <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] m);
        ld_map = m;
        ld     = 1'b1;
        tick();
        ld     = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end();
        for (int i = 0; i < 2000; i++) begin
            if ((done_a || fail_a) && (done_b || fail_b)) break;
            tick();
        end
    endtask

    function automatic int sum_a();
        int s = 0;
        for (int i = 0; i < 16; i++) s += wr_a[i];
        return s;
    endfunction

    function automatic int sum_b();
        int s = 0;
        for (int i = 0; i < 16; i++) s += wr_b[i];
        return s;
    endfunction

    function automatic logic [15:0] once_mask();
        logic [15:0] m = '0;
        for (int i = 0; i < 16; i++) m[i] = (wr_a[i] == 1);
        return m;
    endfunction

    // exp holds move i at bits [2i+1:2i]
    task automatic check_replay(input string tag, input logic [11:0] exp);
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk({tag, "_mv"}, {mv_a, move_a}, {1'b1, exp[2*i +: 2]});
            tick();
        end
        chk({tag, "_end"}, mv_a, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; run = 1'b0; ld = 1'b0; ld_map = '0;
        tick();
        tick();
        chk("rst_outs", {fail_a, done_a, mv_a, rd_a, we_a, move_a}, '0);
        rst = 1'b0;

        // All-open map: straight path, then the shallow stack overflows in DUT b.
        load(16'h0000);
        pulse_start();
        wait_end();
        chk("open_done", {done_a, fail_a}, 2'b10);
        chk("open_writes", sum_a(), 7);
        check_replay("open_rep1", 12'h540);
        check_replay("open_rep2", 12'h540);
        chk("d4_result", {done_b, fail_b}, 2'b01);
        chk("d4_writes", sum_b(), 5);
`ifdef MAZE_CTRL_STATS_EN
        chk("open_bt", bt_a, 16'd0);
`endif

        // Walls (1,3),(2,3): one backtrack from (0,3); restart straight from SOLVED.
        load(16'h0880);
        pulse_start();
        chk("restart_clr", {done_a, fail_a}, 2'b00);
        wait_end();
        chk("detour_done", {done_a, fail_a}, 2'b10);
        check_replay("detour_rep", 12'h150);
`ifdef MAZE_CTRL_STATS_EN
        chk("detour_bt", bt_a, 16'd1);
`endif

        // Walls (2,3),(3,2): goal sealed off, exhaustive search fails.
        load(16'h4800);
        pulse_start();
        wait_end();
        chk("sealed_res", {done_a, fail_a}, 2'b01);
        chk("sealed_once", once_mask(), 16'h37FF);
        chk("sealed_writes", sum_a(), 13);

        // Start cell blocked: fails quickly with no writes; Run in FAILED does nothing.
        load(16'h0001);
        pulse_start();
        for (int i = 0; i < 3 && !fail_a; i++) tick();
        chk("blk_fail", {done_a, fail_a}, 2'b01);
        chk("blk_writes", sum_a(), 0);
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("blk_run_ign", {mv_a, fail_a}, 2'b01);

        // Run before any Start, then a Start pulse mid-search that must be ignored.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        load(16'h0000);
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("idle_run_ign", {mv_a, done_a}, 2'b00);
        tick();
        chk("idle_run_ign2", mv_a, 1'b0);
        pulse_start();
        for (int i = 0; i < 4; i++) tick();
        pulse_start();
        wait_end();
        chk("mid_start_ign", {done_a, fail_a}, 2'b10);
        chk("mid_start_wr", sum_a(), 7);

        // Reset in the middle of a search clears the outputs at the next edge.
        load(16'h0000);
        pulse_start();
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst", {fail_a, done_a, mv_a, rd_a, we_a}, '0);
        rst = 1'b0;
        tick();

        chk("rd_we_excl", excl_bad, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
